// File: rtl/smm_pkg.sv
// Shared types and sizing helpers for the NxN output-stationary systolic multiplier.
package smm_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Growth-safe width: a sum of N full-width products never overflows.
  function automatic int unsigned default_accw(input int unsigned bw, input int unsigned n);
    return 2 * bw + $clog2(n);
  endfunction

  // Counter value on which the result is committed; the last product lands one edge earlier.
  function automatic int unsigned final_count(input int unsigned n);
    return 3 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_mm_nxn_if.sv
// Job handshake and matrix buses between operand loader, multiplier tile and result consumer.
interface systolic_mm_nxn_if
  import smm_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned BW   = 8,
  parameter int unsigned ACCW = default_accw(BW, N)
);

  logic                               start;
  logic [N-1:0][N-1:0][BW-1:0]        a;
  logic [N-1:0][N-1:0][BW-1:0]        b;
  logic                               busy;
  logic                               done;
  logic [N-1:0][N-1:0][ACCW-1:0]      y;

  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);

endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell: registered x (rightward) / y (downward) pass and a local accumulator.
module systolic_pe #(
  parameter int unsigned BW     = 8,
  parameter int unsigned ACCW   = 2 * BW,
  parameter int unsigned SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [BW-1:0]   x_in,
  input  logic [BW-1:0]   y_in,
  output logic [BW-1:0]   x_out,
  output logic [BW-1:0]   y_out,
  output logic [ACCW-1:0] acc
);

  logic [BW-1:0]   xp_q, yp_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] prod_ext;

  if (SIGNED != 0) begin : g_signed
    logic signed [2*BW-1:0] prod;
    assign prod     = $signed({{BW{x_in[BW-1]}}, x_in}) * $signed({{BW{y_in[BW-1]}}, y_in});
    assign prod_ext = ACCW'(prod);
  end else begin : g_unsigned
    logic [2*BW-1:0] prod;
    assign prod     = {{BW{1'b0}}, x_in} * {{BW{1'b0}}, y_in};
    assign prod_ext = ACCW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xp_q  <= '0;
      yp_q  <= '0;
      acc_q <= '0;
    end else if (clr) begin
      xp_q  <= '0;
      yp_q  <= '0;
      acc_q <= '0;
    end else if (en) begin
      xp_q  <= x_in;
      yp_q  <= y_in;
      acc_q <= acc_q + prod_ext;
    end
  end

  assign x_out = xp_q;
  assign y_out = yp_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_nxn.sv
// NxN output-stationary systolic multiplier Y = A x B: one job per start, result held until next done.
module systolic_mm_nxn
  import smm_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned BW     = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned ACCW   = default_accw(BW, N)
) (
  input logic              clk,
  input logic              rst,
  systolic_mm_nxn_if.slave bus
);

  localparam int unsigned CW = $clog2(3 * N);
  localparam int unsigned IW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(final_count(N));

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [N-1:0][N-1:0][BW-1:0]    a_q, b_q;
  logic [N-1:0][N-1:0][ACCW-1:0]  y_q;
  logic                           busy_q, done_q;

  logic                           accept, run, last, en;
  logic [N-1:0][BW-1:0]           feed_x, feed_y;
  logic [BW-1:0]                  xi [N][N];
  logic [BW-1:0]                  yi [N][N];
  logic [BW-1:0]                  xo [N][N];
  logic [BW-1:0]                  yo [N][N];
  logic [ACCW-1:0]                acc [N][N];

  assign accept = (state_q == StIdle) && bus.start;
  assign run    = (state_q == StRun);
  assign last   = (cnt_q == LastCnt);
  assign en     = run && !last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= run && !last;
      done_q <= run && last;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (last) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                y_q[i][j] <= acc[i][j];
              end
            end
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Skewed edge feed: wavefront t = cnt-1, so the count-0 cycle is a bubble after the clear.
  always_comb begin
    int ka;
    int kb;
    feed_x = '0;
    feed_y = '0;
    ka     = 0;
    kb     = 0;
    for (int i = 0; i < N; i++) begin
      ka = int'(cnt_q) - 1 - i;
      if (ka >= 0 && ka < int'(N)) feed_x[i] = a_q[i][ka[IW-1:0]];
    end
    for (int j = 0; j < N; j++) begin
      kb = int'(cnt_q) - 1 - j;
      if (kb >= 0 && kb < int'(N)) feed_y[j] = b_q[kb[IW-1:0]][j];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_xedge
        assign xi[gi][gj] = feed_x[gi];
      end else begin : g_xlink
        assign xi[gi][gj] = xo[gi][gj-1];
      end
      if (gi == 0) begin : g_yedge
        assign yi[gi][gj] = feed_y[gj];
      end else begin : g_ylink
        assign yi[gi][gj] = yo[gi-1][gj];
      end

      systolic_pe #(
        .BW     (BW),
        .ACCW   (ACCW),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (en),
        .x_in  (xi[gi][gj]),
        .y_in  (yi[gi][gj]),
        .x_out (xo[gi][gj]),
        .y_out (yo[gi][gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;

endmodule
